// File: rtl/cnt_rr_sched.sv
// cnt_rr_sched: round-robin owner of one shared load/enable counter.
// Accepts a job, loads base, issues len enables, checks result, pulses done.
module cnt_rr_sched #(
  parameter int WIDTH = 5,
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_base,
  input  logic [NREQ*WIDTH-1:0] req_len,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  stall,
  input  logic                  abort,
  output logic                  cnt_load,
  output logic                  cnt_enab,
  output logic [WIDTH-1:0]      cnt_in,
  input  logic [WIDTH-1:0]      cnt_out,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id,
  output logic [NREQ-1:0]       done,
  output logic                  aborted,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_last;
  logic [IDW-1:0]   r_gid;
  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_len;
  logic [WIDTH-1:0] r_rem;
  logic             r_err;
  logic             r_aborted;

  logic [IDW-1:0]   w_win;
  logic             w_found;
  logic [WIDTH-1:0] w_exp;
  logic             w_enab;
  logic             w_last_step;

  // Scan starts just past the previous owner so nobody starves.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_last) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win   = IDW'((int'(r_last) + k) % NREQ);
      end
    end
  end

  assign w_exp       = r_base + r_len;
  assign w_enab      = (r_state == S_RUN) && !stall;
  assign w_last_step = w_enab && (r_rem == WIDTH'(1));

  assign req_ready = (r_state == S_IDLE && w_found)
                   ? (NREQ'(1) << w_win) : '0;
  assign cnt_load  = (r_state == S_LOAD);
  assign cnt_enab  = w_enab;
  assign cnt_in    = (r_state == S_LOAD) ? r_base : '0;
  assign busy      = (r_state != S_IDLE);
  assign grant_id  = r_gid;
  assign done      = (r_state == S_DONE)
                   ? (NREQ'(1) << r_gid) : '0;
  assign aborted   = (r_state == S_DONE) && r_aborted;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last    <= IDW'(NREQ - 1);
      r_gid     <= '0;
      r_base    <= '0;
      r_len     <= '0;
      r_rem     <= '0;
      r_err     <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gid     <= w_win;
            r_base    <= req_base[w_win*WIDTH +: WIDTH];
            r_len     <= req_len[w_win*WIDTH +: WIDTH];
            r_aborted <= 1'b0;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_rem <= r_len;
          if (abort) begin
            r_aborted <= 1'b1;
            r_state   <= S_DONE;
          end else if (r_len != '0) begin
            r_state <= S_RUN;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_RUN: begin
          if (w_enab)
            r_rem <= r_rem - WIDTH'(1);
          if (abort) begin
            r_aborted <= 1'b1;
            r_state   <= S_DONE;
          end else if (w_last_step) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Aborted jobs stop early, so their final value is meaningless.
          if (!r_aborted && cnt_out != w_exp)
            r_err <= 1'b1;
          r_last  <= r_gid;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  a_excl: assert property (
    @(posedge clk) disable iff (rst) !(cnt_load && cnt_enab)
  );

endmodule

// File: tb/tb_cnt_rr_sched.sv
// tb_cnt_rr_sched: scoreboard bench with a behavioural counter.
// Jobs are queued at accept and checked when done pulses.
module tb_cnt_rr_sched;
  localparam int W = 5;
  localparam int N = 2;
  localparam int IDW = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_base;
  logic [N*W-1:0] req_len;
  logic [N-1:0]   req_ready;
  logic           stall;
  logic           abort;
  logic           cnt_load;
  logic           cnt_enab;
  logic [W-1:0]   cnt_in;
  logic [W-1:0]   cnt_out;
  logic           busy;
  logic [IDW-1:0] grant_id;
  logic [N-1:0]   done;
  logic           aborted;
  logic           err;

  always #5 clk = ~clk;

  cnt_rr_sched #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_base(req_base),
    .req_len(req_len), .req_ready(req_ready),
    .stall(stall), .abort(abort),
    .cnt_load(cnt_load), .cnt_enab(cnt_enab),
    .cnt_in(cnt_in), .cnt_out(cnt_out),
    .busy(busy), .grant_id(grant_id),
    .done(done), .aborted(aborted), .err(err)
  );

  // Counter model; fault makes it ignore enab.
  logic         fault;
  logic [W-1:0] r_cnt;
  always @(posedge clk) begin
    if (rst)           r_cnt <= '0;
    else if (cnt_load) r_cnt <= cnt_in;
    else if (cnt_enab && !fault) r_cnt <= r_cnt + 1'b1;
  end
  assign cnt_out = r_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    int           id;
    logic [W-1:0] base;
    logic [W-1:0] fin;
    int           len;
    int           acc;
    int           lat;
    logic         ab;
  } job_t;

  job_t q[$];
  int   grants[$];
  int   m_last = N - 1;
  logic exp_err = 1'b0;
  int   enab_n = 0;

  function automatic int arb(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  int           m_w;
  logic [N-1:0] m_er;
  job_t         m_j;
  logic [W-1:0] m_good;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_last  = N - 1;
      exp_err = 1'b0;
      enab_n  = 0;
    end else begin
      m_w = arb(req_valid, m_last);
      if (!busy) begin
        m_er = (m_w < 0) ? '0 : N'(1) << m_w;
        chk("ready", req_ready, m_er);
      end
      chk("excl", cnt_load & cnt_enab, 0);
      if (cnt_enab) enab_n++;
      if (|(req_valid & req_ready) && m_w >= 0) begin
        m_j.id   = m_w;
        m_j.base = req_base[m_w*W +: W];
        m_j.len  = int'(req_len[m_w*W +: W]);
        m_j.fin  = fault ? m_j.base : m_j.base + W'(m_j.len);
        m_j.acc  = cyc;
        m_j.lat  = 2 + m_j.len;
        m_j.ab   = 1'b0;
        q.push_back(m_j);
        grants.push_back(m_w);
        enab_n = 0;
      end
      if (cnt_load) begin
        if (q.size() == 0) chk("load_spur", cnt_load, 0);
        else begin
          chk("load_in", cnt_in, q[0].base);
          chk("load_lat", cyc - q[0].acc, 1);
        end
      end
      if (done == '0) begin
        chk("ab_idle", aborted, 0);
      end else if (q.size() == 0) begin
        chk("done_spur", done, 0);
      end else begin
        m_j = q.pop_front();
        chk("done_id", done, N'(1) << m_j.id);
        chk("gid", grant_id, m_j.id);
        chk("aborted", aborted, m_j.ab);
        chk("final", cnt_out, m_j.fin);
        chk("lat", cyc - m_j.acc, m_j.lat);
        if (!m_j.ab) chk("enabs", enab_n, m_j.len);
        chk("err_pre", err, exp_err);
        m_good = m_j.base + W'(m_j.len);
        if (!m_j.ab && m_j.fin != m_good) exp_err = 1'b1;
        m_last = m_j.id;
      end
    end
  end

  // Returns one cycle after the accept (DUT in LOAD).
  task automatic issue(input int i, input int base, input int len);
    int n = 0;
    req_base[i*W +: W] = W'(base);
    req_len[i*W +: W]  = W'(len);
    req_valid[i] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 300);
    if (!req_ready[i]) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((q.size() != 0 || busy) && n < 300);
    if (q.size() != 0 || busy) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  job_t t;

  initial begin
    rst = 1'b1; req_valid = '0; req_base = '0; req_len = '0;
    stall = 1'b0; abort = 1'b0; fault = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", aborted, 0);
    chk("rst_load", cnt_load, 0);
    chk("rst_enab", cnt_enab, 0);
    chk("rst_cin", cnt_in, 0);
    chk("rst_err", err, 0);
    chk("rst_gid", grant_id, 0);
    step(); rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
    end
    step();

    grants.delete();
    fork
      begin issue(0, 1, 1); issue(0, 5, 1); end
      begin issue(1, 10, 1); issue(1, 20, 1); end
    join
    wait_idle();
    chk("fair_n", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      chk("fair_order", grants[k], k % 2);

    issue(0, 3, 4);  wait_idle();
    issue(1, 30, 4); wait_idle();
    issue(0, 9, 0);  wait_idle();

    issue(1, 0, 4);
    t = q[0]; t.lat = t.lat + 2; q[0] = t;
    step(); step();
    stall = 1'b1;
    step(); step();
    stall = 1'b0;
    wait_idle();

    issue(0, 12, 4);
    step(); step();
    abort = 1'b1;
    t = q[0]; t.ab = 1'b1; t.lat = 4; t.fin = 5'd14; q[0] = t;
    step();
    abort = 1'b0;
    wait_idle();
    chk("abort_err", err, 0);

    fault = 1'b1;
    issue(0, 3, 4); wait_idle();
    fault = 1'b0;
    chk("err_set", err, 1);
    issue(1, 1, 2); wait_idle();
    chk("err_sticky", err, 1);

    issue(0, 4, 8);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rr_busy", busy, 0);
    chk("rr_done", done, 0);
    chk("rr_err", err, 0);
    repeat (10) step();

    fork
      issue(1, 7, 2);
      issue(0, 2, 3);
    join
    wait_idle();
    chk("post_rst_first", grants[grants.size()-2], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/cnt_rr_sched.md
Name: cnt_rr_sched

Overview:
- Round-robin scheduler that shares one WIDTH-bit load/enable counter among NREQ requesters.
- Each request carries a start value and an increment count.
- The block accepts one request, loads the counter, and enables it for exactly the requested number of increments (honouring stall).
- It then checks the final counter value and pulses done to the owner.
- Sits between request sources and a single counter instance; the counter's rst is tied to the same rst.

Parameters:
WIDTH, 5, counter/value width in bits
NREQ, 2, number of requesters (>=2)
IDW, $clog2(NREQ), width of grant_id

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  per-requester request valid
req_base  in  NREQ*WIDTH  start value; requester i in bits [i*WIDTH +: WIDTH]
req_len  in  NREQ*WIDTH  increment count, same packing
req_ready  out  NREQ  one-hot accept strobe
stall  in  1  hold counter (suppress enable) while high
abort  in  1  terminate the current job
cnt_load  out  1  to counter load
cnt_enab  out  1  to counter enab
cnt_in  out  WIDTH  to counter cnt_in
cnt_out  in  WIDTH  from counter cnt_out
busy  out  1  high in any state but IDLE
grant_id  out  IDW  index of current owner, held from accept through DONE
done  out  NREQ  one-cycle completion pulse to owner
aborted  out  1  valid with done; 1 if the job was aborted
err  out  1  sticky final-value mismatch flag

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=IDLE; last_grant=NREQ-1 (requester 0 wins first).
  - err=0, grant_id=0.
  - All strobes (req_ready, done, aborted, cnt_load, cnt_enab) = 0; cnt_in=0.
  - rst in any state, including mid-RUN, returns to IDLE next cycle with no done pulse.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning (last_grant+1) mod NREQ upward with wrap.
  - req_ready[winner]=1 combinationally in the same cycle; handshake completes on valid&ready.
  - On handshake, latch base, len and id; go to LOAD.
  - Requesters hold valid and fields stable until ready.
- LOAD (1 cycle):
  - cnt_load=1, cnt_in=latched base, cnt_enab=0.
  - Next state is RUN if len!=0, else DONE.
  - remaining=len.
- RUN:
  - cnt_enab = ~stall.
  - Each cycle with cnt_enab=1 decrements remaining.
  - When cnt_enab=1 and remaining==1, next state is DONE.
  - Exactly len enabled cycles are issued.
- DONE (1 cycle):
  - done[grant_id]=1.
  - If not aborted and cnt_out != (base+len) mod 2^WIDTH, set err=1.
  - last_grant=grant_id; next state IDLE; no accept in this cycle.
- abort:
  - Sampled in LOAD or RUN.
  - If abort=1, outputs in that cycle are still driven per state.
  - Next state is DONE with aborted=1, and the err check is skipped.
  - abort is ignored in IDLE and DONE.
- Arithmetic is modulo 2^WIDTH; counter wrap-around is legal and not an error.
- Latency: accept at cycle t; LOAD at t+1; first enable at t+2; done at t+2+len+(stall cycles), or t+2 for len=0.
- Minimum request spacing: the same requester can be re-accepted no earlier than the cycle after DONE. Round-robin guarantees no starvation; with all valid, each requester waits at most NREQ-1 jobs.
- cnt_load and cnt_enab are never both 1.

Test Plan:
- Reset: rst=1 for 2 cycles -> busy=0, all strobes 0, err=0; deassert with no valid -> stays IDLE.
- Single job: req0 base=3 len=4, accept at cycle 0:
  - cycle 1: cnt_load=1, cnt_in=3.
  - cycles 2-5: cnt_enab=1.
  - cycle 6: done[0]=1, cnt_out=7, err=0.
- Fairness: req0 and req1 held valid with len=1 -> grant order 0,1,0,1; each done at accept+3; no starvation.
- Wrap and zero length:
  - base=30 len=4 -> final cnt_out=2, err=0.
  - len=0 -> LOAD then DONE next cycle, zero enables, cnt_out=base.
- Stall and abort:
  - stall=1 for 2 cycles mid-RUN with len=4 -> done 2 cycles later, still exactly 4 enables.
  - abort in 2nd RUN cycle -> DONE next cycle, aborted=1, err unchanged.
- Fault and reset: counter model ignores enab, job base=3 len=4 -> err=1 at DONE, remains 1 across later jobs until rst; rst during RUN -> IDLE next cycle, no done.
